// File: rtl/ysyx_25060170_pkg.sv
// Shared types for the ysyx_25060170 writeback path.
// Writeback source select, load size and WBU state encodings.
package ysyx_25060170_pkg;

    typedef enum logic [1:0] {
        WB_EXU = 2'd0,
        WB_LSU = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LOAD = 2'd1,
        S_COMMIT    = 2'd2
    } wbu_state_e;

endpackage

// File: rtl/ysyx_25060170_load_ext.sv
// Load lane select and sign/zero extension.
// Purely combinational; offset is aligned to the access size.
module ysyx_25060170_load_ext
    import ysyx_25060170_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_raw,
    input  logic [2:0]      i_off,
    input  ld_size_e        i_size,
    input  logic            i_unsigned,
    output logic [XLEN-1:0] o_data
);

    localparam logic [2:0] OFF_MASK = 3'(XLEN / 8 - 1);

    logic [2:0]      w_off;
    logic [XLEN-1:0] w_sh;

    always_comb begin
        w_off = i_off & OFF_MASK;
        case (i_size)
            LD_B:    w_off = w_off;
            LD_H:    w_off = w_off & 3'b110;
            LD_W:    w_off = w_off & 3'b100;
            default: w_off = 3'b000;
        endcase
    end

    assign w_sh = i_raw >> {w_off, 3'b000};

    always_comb begin
        o_data = w_sh;
        case (i_size)
            LD_B: begin
                if (i_unsigned) o_data = XLEN'(w_sh[7:0]);
                else            o_data = XLEN'($signed(w_sh[7:0]));
            end
            LD_H: begin
                if (i_unsigned) o_data = XLEN'(w_sh[15:0]);
                else            o_data = XLEN'($signed(w_sh[15:0]));
            end
            LD_W: begin
                // With XLEN=32 both casts leave the word untouched
                if (i_unsigned) o_data = XLEN'(w_sh[31:0]);
                else            o_data = XLEN'($signed(w_sh[31:0]));
            end
            default: o_data = w_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_25060170_wbu_stage.sv
// Writeback stage: source select, load extension, registered RF port.
// Stalls upstream while a load response is outstanding.
module ysyx_25060170_wbu_stage
    import ysyx_25060170_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_regw,
    input  logic [1:0]         in_sel,
    input  logic [XLEN-1:0]    in_exu_result,
    input  logic [XLEN-1:0]    in_csr_rdata,
    input  logic [1:0]         in_ld_size,
    input  logic               in_ld_unsigned,
    input  logic [2:0]         in_ld_off,
    input  logic               lsu_rvalid,
    input  logic [XLEN-1:0]    lsu_rdata,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               commit_valid,
    output logic [XLEN-1:0]    commit_pc,
    output logic               pend_valid,
    output logic [RADDR_W-1:0] pend_rd
);

    wbu_state_e         r_state;
    wbu_state_e         w_next;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_val;
    logic [RADDR_W-1:0] r_rd;
    logic               r_regw;
    ld_size_e           r_ld_size;
    logic               r_ld_uns;
    logic [2:0]         r_ld_off;

    logic               w_wait;
    logic               w_commit;
    logic               w_accept;
    logic               w_is_load;
    logic [XLEN-1:0]    w_nl_val;
    logic [XLEN-1:0]    w_ld_val;

    assign w_wait    = (r_state == S_WAIT_LOAD);
    assign w_commit  = (r_state == S_COMMIT);
    assign in_ready  = !w_wait;
    assign w_accept  = in_valid && in_ready;
    assign w_is_load = (wb_sel_e'(in_sel) == WB_LSU);

    always_comb begin
        w_nl_val = in_exu_result;
        case (wb_sel_e'(in_sel))
            WB_PC4:  w_nl_val = in_pc + XLEN'(4);
            WB_CSR:  w_nl_val = in_csr_rdata;
            default: w_nl_val = in_exu_result;
        endcase
    end

    ysyx_25060170_load_ext #(
        .XLEN(XLEN)
    ) u_load_ext (
        .i_raw     (lsu_rdata),
        .i_off     (r_ld_off),
        .i_size    (r_ld_size),
        .i_unsigned(r_ld_uns),
        .o_data    (w_ld_val)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_COMMIT: begin
                if (w_accept) w_next = w_is_load ? S_WAIT_LOAD : S_COMMIT;
                else          w_next = S_IDLE;
            end
            S_WAIT_LOAD: begin
                if (lsu_rvalid) w_next = S_COMMIT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= '0;
            r_val     <= '0;
            r_rd      <= '0;
            r_regw    <= 1'b0;
            r_ld_size <= LD_B;
            r_ld_uns  <= 1'b0;
            r_ld_off  <= '0;
        end else if (w_accept) begin
            r_pc      <= in_pc;
            r_rd      <= in_rd;
            r_regw    <= in_regw;
            r_ld_size <= ld_size_e'(in_ld_size);
            r_ld_uns  <= in_ld_unsigned;
            r_ld_off  <= in_ld_off;
            if (!w_is_load) r_val <= w_nl_val;
        end else if (w_wait && lsu_rvalid) begin
            r_val <= w_ld_val;
        end
    end

    assign rf_we        = w_commit && r_regw && (r_rd != '0);
    assign rf_waddr     = r_rd;
    assign rf_wdata     = r_val;
    assign commit_valid = w_commit;
    assign commit_pc    = r_pc;
    assign pend_valid   = w_wait;
    assign pend_rd      = w_wait ? r_rd : '0;

endmodule

// File: tb/tb_ysyx_25060170_wbu_stage.sv
// Self-checking bench for ysyx_25060170_wbu_stage (XLEN=32).
// Directed steps plus randomized traffic against a reference model.
module tb_ysyx_25060170_wbu_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_regw;
    logic [1:0]  in_sel;
    logic [31:0] in_exu_result;
    logic [31:0] in_csr_rdata;
    logic [1:0]  in_ld_size;
    logic        in_ld_unsigned;
    logic [2:0]  in_ld_off;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        pend_valid;
    logic [4:0]  pend_rd;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] e_pc;
    logic [31:0] e_val;
    logic [4:0]  e_rd;
    logic        e_we;

    always #5 clk = ~clk;

    ysyx_25060170_wbu_stage #(
        .XLEN(32),
        .RADDR_W(5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_rd         (in_rd),
        .in_regw       (in_regw),
        .in_sel        (in_sel),
        .in_exu_result (in_exu_result),
        .in_csr_rdata  (in_csr_rdata),
        .in_ld_size    (in_ld_size),
        .in_ld_unsigned(in_ld_unsigned),
        .in_ld_off     (in_ld_off),
        .lsu_rvalid    (lsu_rvalid),
        .lsu_rdata     (lsu_rdata),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .commit_valid  (commit_valid),
        .commit_pc     (commit_pc),
        .pend_valid    (pend_valid),
        .pend_rd       (pend_rd)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: take the naturally aligned lane, then extend arithmetically
    function automatic logic [31:0] ref_load(logic [31:0] raw, int off,
                                             int size, bit uns);
        int     nb;
        int     a;
        longint v;
        if (size >= 2) return raw;
        nb = 1 << size;
        a  = (off % 4) - ((off % 4) % nb);
        v  = (longint'(raw) >> (8 * a)) % (longint'(1) << (8 * nb));
        if (!uns && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    task automatic send_nl(input logic [31:0] pc, input logic [4:0] rd,
                           input logic regw, input logic [1:0] sel,
                           input logic [31:0] exu, input logic [31:0] csr);
        in_valid      = 1'b1;
        in_pc         = pc;
        in_rd         = rd;
        in_regw       = regw;
        in_sel        = sel;
        in_exu_result = exu;
        in_csr_rdata  = csr;
        in_ld_size    = 2'($urandom_range(0, 2));
        in_ld_off     = 3'($urandom);
        e_pc = pc;
        e_rd = rd;
        e_we = regw && (rd != 5'd0);
        case (sel)
            2'd2:    e_val = pc + 32'd4;
            2'd3:    e_val = csr;
            default: e_val = exu;
        endcase
    endtask

    task automatic chk_commit(input string tag);
        chk({tag, ".commit_valid"}, commit_valid, 1);
        chk({tag, ".commit_pc"}, commit_pc, e_pc);
        chk({tag, ".rf_we"}, rf_we, e_we);
        chk({tag, ".rf_waddr"}, rf_waddr, e_rd);
        chk({tag, ".rf_wdata"}, rf_wdata, e_val);
        chk({tag, ".pend_valid"}, pend_valid, 0);
    endtask

    task automatic run_load(input string tag, input logic [31:0] pc,
                            input logic [4:0] rd, input logic regw,
                            input int off, input int size, input bit uns,
                            input logic [31:0] raw, input int waitc);
        in_valid       = 1'b1;
        in_pc          = pc;
        in_rd          = rd;
        in_regw        = regw;
        in_sel         = 2'd1;
        in_exu_result  = $urandom;
        in_csr_rdata   = $urandom;
        in_ld_size     = 2'(size);
        in_ld_unsigned = uns;
        in_ld_off      = 3'(off);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < waitc; i++) begin
            lsu_rvalid = 1'b0;
            lsu_rdata  = $urandom;
            chk({tag, ".wait_ready"}, in_ready, 0);
            chk({tag, ".pend_valid"}, pend_valid, 1);
            chk({tag, ".pend_rd"}, pend_rd, rd);
            chk({tag, ".wait_commit"}, commit_valid, 0);
            step();
        end
        lsu_rvalid = 1'b1;
        lsu_rdata  = raw;
        e_pc  = pc;
        e_rd  = rd;
        e_we  = regw && (rd != 5'd0);
        e_val = ref_load(raw, off, size, uns);
        step();
        lsu_rvalid = 1'b0;
        lsu_rdata  = $urandom;
        chk_commit(tag);
    endtask

    initial begin
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_pc          = '0;
        in_rd          = '0;
        in_regw        = 1'b0;
        in_sel         = '0;
        in_exu_result  = '0;
        in_csr_rdata   = '0;
        in_ld_size     = '0;
        in_ld_unsigned = 1'b0;
        in_ld_off      = '0;
        lsu_rvalid     = 1'b0;
        lsu_rdata      = '0;

        repeat (3) step();
        chk("rst.rf_we", rf_we, 0);
        chk("rst.rf_waddr", rf_waddr, 0);
        chk("rst.rf_wdata", rf_wdata, 0);
        chk("rst.commit_valid", commit_valid, 0);
        chk("rst.commit_pc", commit_pc, 0);
        chk("rst.pend_valid", pend_valid, 0);
        chk("rst.pend_rd", pend_rd, 0);
        chk("rst.in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();
        step();
        chk("idle.commit_valid", commit_valid, 0);
        chk("idle.in_ready", in_ready, 1);

        send_nl(32'h8000_0000, 5'd5, 1'b1, 2'd0, 32'h1234_5678, 32'h0);
        step();
        in_valid = 1'b0;
        chk_commit("exu");
        step();
        chk("exu.after", commit_valid, 0);

        send_nl(32'h8000_0000, 5'd1, 1'b1, 2'd2, 32'h0, 32'h0);
        step();
        chk_commit("pc4a");
        chk("pc4a.wdata_lit", rf_wdata, 32'h8000_0004);
        chk("pc4a.in_ready", in_ready, 1);
        send_nl(32'hFFFF_FFFC, 5'd1, 1'b1, 2'd2, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        chk_commit("pc4b");
        chk("pc4b.wdata_lit", rf_wdata, 32'h0000_0000);
        chk("pc4b.in_ready", in_ready, 1);
        step();

        run_load("lb", 32'h8000_0010, 5'd7, 1'b1, 3, 0, 1'b0,
                 32'h80FF_0000, 2);
        chk("lb.lit", rf_wdata, 32'hFFFF_FF80);
        step();
        run_load("lbu", 32'h8000_0014, 5'd7, 1'b1, 3, 0, 1'b1,
                 32'h80FF_0000, 2);
        chk("lbu.lit", rf_wdata, 32'h0000_0080);
        step();
        run_load("lh", 32'h8000_0018, 5'd9, 1'b1, 2, 1, 1'b0,
                 32'h80FF_0000, 0);
        chk("lh.lit", rf_wdata, 32'hFFFF_80FF);
        step();
        run_load("lw", 32'h8000_001C, 5'd9, 1'b1, 1, 2, 1'b0,
                 32'hDEAD_BEEF, 1);
        chk("lw.lit", rf_wdata, 32'hDEAD_BEEF);
        step();

        send_nl(32'h8000_0020, 5'd0, 1'b1, 2'd3, 32'h0, 32'hCAFE_F00D);
        step();
        in_valid = 1'b0;
        chk_commit("x0");
        chk("x0.rf_we_lit", rf_we, 0);
        step();

        // Stray load response outside WAIT_LOAD must be ignored
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'h1111_1111;
        step();
        lsu_rvalid = 1'b0;
        chk("stray.commit", commit_valid, 0);
        chk("stray.wdata", rf_wdata, 32'hCAFE_F00D);

        in_valid       = 1'b1;
        in_pc          = 32'h8000_0030;
        in_rd          = 5'd12;
        in_regw        = 1'b1;
        in_sel         = 2'd1;
        in_ld_size     = 2'd2;
        in_ld_unsigned = 1'b0;
        in_ld_off      = 3'd0;
        step();
        in_valid = 1'b0;
        step();
        chk("rstw.pend_before", pend_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rstw.pend_async", pend_valid, 0);
        chk("rstw.ready_async", in_ready, 1);
        step();
        rst_n = 1'b1;
        step();
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'h5555_AAAA;
        step();
        lsu_rvalid = 1'b0;
        chk("rstw.commit", commit_valid, 0);
        chk("rstw.rf_we", rf_we, 0);
        step();
        chk("rstw.commit2", commit_valid, 0);
        send_nl(32'h8000_0040, 5'd3, 1'b1, 2'd0, 32'h0BAD_CAFE, 32'h0);
        step();
        in_valid = 1'b0;
        chk_commit("rstw.next");
        step();

        for (int n = 0; n < 60; n++) begin
            int          kind;
            logic [31:0] pc;
            logic [4:0]  rd;
            pc   = $urandom & 32'hFFFF_FFFC;
            rd   = 5'($urandom);
            kind = $urandom_range(0, 3);
            if (kind == 1) begin
                run_load("rnd.ld", pc, rd, 1'($urandom),
                         $urandom_range(0, 7), $urandom_range(0, 2),
                         1'($urandom), $urandom, $urandom_range(0, 3));
            end else begin
                send_nl(pc, rd, 1'($urandom), 2'(kind), $urandom, $urandom);
                step();
                if ($urandom_range(0, 1) == 0) in_valid = 1'b0;
                chk_commit("rnd.nl");
            end
            if (!in_valid || $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                step();
                chk("rnd.idle", commit_valid, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ysyx_25060170_wbu_stage.md
# ysyx_25060170_wbu_stage

Parametrised, handshaked writeback stage for the ysyx_25060170 core. It sits after EXU/LSU and selects the writeback value from four sources: EXU result, load data, PC+4, or CSR read data. It sign- or zero-extends sub-word load data and drives a registered register-file write port plus a one-cycle commit pulse. It stalls the upstream stage while a load response is outstanding and exposes the pending destination register for hazard detection.

## Interface
Parameters:
- XLEN, 32, datapath width (32 or 64)
- RADDR_W, 5, register address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction this cycle
- in_pc  in  XLEN  instruction PC
- in_rd  in  RADDR_W  destination register
- in_regw  in  1  instruction writes rd
- in_sel  in  2  source select: 0 EXU, 1 LSU, 2 PC+4, 3 CSR
- in_exu_result  in  XLEN  EXU result
- in_csr_rdata  in  XLEN  CSR read data
- in_ld_size  in  2  load size: 0 byte, 1 half, 2 word, 3 dword (XLEN=64 only)
- in_ld_unsigned  in  1  zero-extend the load
- in_ld_off  in  3  load address low bits, used for lane select
- lsu_rvalid  in  1  load data valid
- lsu_rdata  in  XLEN  raw aligned load word
- rf_we  out  1  register-file write enable
- rf_waddr  out  RADDR_W  write address
- rf_wdata  out  XLEN  write data
- commit_valid  out  1  instruction retired this cycle
- commit_pc  out  XLEN  PC of the retired instruction
- pend_valid  out  1  a load writeback is outstanding
- pend_rd  out  RADDR_W  rd of the outstanding load

## Operation
- FSM states: IDLE, WAIT_LOAD, COMMIT.
- in_ready = (state != WAIT_LOAD). An accept is in_valid && in_ready.
- On accept, the stage latches pc, rd, regw, sel and the load attributes.
  - sel≠LSU: the write value is also latched (EXU result, CSR data, or in_pc+4 mod 2^XLEN). Next state is COMMIT.
  - sel=LSU: next state is WAIT_LOAD.
- WAIT_LOAD:
  - pend_valid=1 and pend_rd=latched rd.
  - When lsu_rvalid is high, extract the lane at byte offset in_ld_off (aligned to size, masked to the word width), extend it per size and unsigned, latch the result, and go to COMMIT.
  - While lsu_rvalid is low, stay in WAIT_LOAD.
- COMMIT:
  - commit_valid=1, commit_pc=latched pc.
  - rf_we = regw && rd!=0; rf_waddr=rd; rf_wdata=latched value.
  - If an accept occurs in the same cycle, go to the next instruction's state. Otherwise go to IDLE.
- lsu_rvalid is ignored outside WAIT_LOAD.
- rd=0 retires normally: commit_valid=1, rf_we=0.
- Word load with XLEN=32 passes lsu_rdata through unchanged.

## Timing
- Reset values: state IDLE, and rf_we, rf_waddr, rf_wdata, commit_valid, commit_pc, pend_valid, pend_rd all 0. in_ready=1 in IDLE.
- Non-load latency: accept at cycle t gives COMMIT outputs at t+1. Throughput is one instruction per cycle with in_valid held.
- Load latency: accept at t puts the stage in WAIT_LOAD from t+1. The earliest lsu_rvalid sampled is at t+1. lsu_rvalid at cycle u gives commit at u+1.
- All outputs come from registers or state decode. There is no combinational path from in_* to rf_*, commit_* or pend_*. in_ready depends only on state.
- Reset asserted mid-operation returns immediately to IDLE. Any pending load is dropped and never commits. A late lsu_rvalid after reset is ignored.

## Structure
- Shared package ysyx_25060170_pkg holds:
  - the wb_sel enum (EXU/LSU/PC4/CSR)
  - the ld_size enum
  - the FSM state enum
- Sub-module ysyx_25060170_load_ext: combinational lane select plus sign/zero extension, parametrised by XLEN.

## Test plan
- Reset: hold rst_n low, then release. All outputs are 0, in_ready=1, and there is no commit until the first accept.
- EXU write: sel=0, rd=5, regw=1, result 0x12345678, pc 0x80000000. Next cycle: rf_we=1, waddr=5, wdata=0x12345678, commit_pc=0x80000000.
- Back-to-back PC+4: pc 0x80000000 then 0xFFFFFFFC, both rd=1. Consecutive cycles give wdata 0x80000004 then 0x00000000 (wrap). in_ready stays 1.
- Load byte: off=3, lsu_rdata 0x80FF0000, signed, lsu_rvalid 3 cycles after accept.
  - During the wait: in_ready=0, pend_valid=1, pend_rd=rd.
  - Commit gives wdata 0xFFFFFF80.
  - Repeating with unsigned gives 0x00000080. A signed half at off=2 gives 0xFFFF80FF.
- x0 destination: rd=0, regw=1, sel=CSR. commit_valid=1, rf_we=0.
- Reset in WAIT_LOAD: assert rst_n low while waiting, release, then pulse lsu_rvalid. There is no commit and no rf_we, and the next EXU instruction commits normally.
